// File: rtl/udp_payload_extractor.sv
// UDP receive path: parses an 8-bit Avalon-ST Ethernet/IPv4/UDP frame and forwards only the payload.
// Optional IPv4 header checksum verification is enabled by defining UDP_RX_IP_CSUM_CHECK_EN.
module udp_payload_extractor #(
    parameter logic [15:0] LOCAL_PORT = 16'd5000,
    parameter int          CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          cfg_local_ip,
    output logic                 in_ready,
    input  logic                 in_valid,
    input  logic [7:0]           in_data,
    input  logic                 in_startofpacket,
    input  logic                 in_endofpacket,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic [7:0]           out_data,
    output logic                 out_startofpacket,
    output logic                 out_endofpacket,
    output logic                 out_error,
    output logic [31:0]          out_src_ip,
    output logic [15:0]          out_src_port,
    output logic [15:0]          out_len,
    output logic [CNT_WIDTH-1:0] drop_count
);

    // Handshake: a beat transfers on a rising edge where valid and ready are both high;
    // valid never depends on ready, and a source holds its beat until it is taken.

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HDR     = 2'd1,
        PAYLOAD = 2'd2,
        DROP    = 2'd3
    } state_t;

    state_t      state, state_nxt;
    logic [5:0]  byte_cnt;
    logic        reject;
    logic [31:0] src_ip_q;
    logic [15:0] src_port_q;
    logic [15:0] udp_len_q;
    logic [15:0] remaining;
    logic        first_byte;

    logic beat;
    logic hdr_bad;
    logic csum_bad;
    logic last_hdr;
    logic reject_all;
    logic accept;
    logic drop_inc;

    assign beat       = in_valid & in_ready;
    assign last_hdr   = (state == HDR) && (byte_cnt == 6'd41);
    assign reject_all = reject | hdr_bad | csum_bad | (udp_len_q <= 16'd8);
    assign accept     = beat & last_hdr & ~reject_all & ~in_endofpacket;

    always_comb begin
        in_ready = 1'b0;
        if (!reset)
            in_ready = (state == PAYLOAD) ? (out_ready | ~out_valid) : 1'b1;
    end

    // Fixed-value header fields; any mismatch is remembered until the byte-41 decision.
    always_comb begin
        hdr_bad = 1'b0;
        case (byte_cnt)
            6'd12:   hdr_bad = (in_data != 8'h08);
            6'd13:   hdr_bad = (in_data != 8'h00);
            6'd14:   hdr_bad = (in_data != 8'h45);
            6'd23:   hdr_bad = (in_data != 8'h11);
            6'd30:   hdr_bad = (in_data != cfg_local_ip[31:24]);
            6'd31:   hdr_bad = (in_data != cfg_local_ip[23:16]);
            6'd32:   hdr_bad = (in_data != cfg_local_ip[15:8]);
            6'd33:   hdr_bad = (in_data != cfg_local_ip[7:0]);
            6'd36:   hdr_bad = (in_data != LOCAL_PORT[15:8]);
            6'd37:   hdr_bad = (in_data != LOCAL_PORT[7:0]);
            default: hdr_bad = 1'b0;
        endcase
    end

`ifdef UDP_RX_IP_CSUM_CHECK_EN
    logic [15:0] csum;
    logic [7:0]  csum_hi;
    logic [16:0] csum_add;

    assign csum_add = {1'b0, csum} + {1'b0, csum_hi, in_data};
    assign csum_bad = (csum != 16'hFFFF);

    // Ones-complement sum over the IPv4 header words with end-around carry.
    always_ff @(posedge clk) begin
        if (reset) begin
            csum    <= 16'd0;
            csum_hi <= 8'd0;
        end else if (state == IDLE && beat && in_startofpacket) begin
            csum    <= 16'd0;
        end else if (state == HDR && beat && byte_cnt >= 6'd14 && byte_cnt <= 6'd33) begin
            if (!byte_cnt[0])
                csum_hi <= in_data;
            else
                csum <= csum_add[15:0] + {15'd0, csum_add[16]};
        end
    end
`else
    assign csum_bad = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        drop_inc  = 1'b0;
        case (state)
            IDLE: begin
                if (beat && in_startofpacket) begin
                    if (in_endofpacket)
                        drop_inc = 1'b1;
                    else
                        state_nxt = HDR;
                end
            end
            HDR: begin
                if (beat) begin
                    if (byte_cnt == 6'd41) begin
                        if (reject_all || in_endofpacket) begin
                            drop_inc  = 1'b1;
                            state_nxt = in_endofpacket ? IDLE : DROP;
                        end else begin
                            state_nxt = PAYLOAD;
                        end
                    end else if (in_endofpacket) begin
                        drop_inc  = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            PAYLOAD: begin
                if (beat) begin
                    if (remaining == 16'd1)
                        state_nxt = in_endofpacket ? IDLE : DROP;
                    else if (in_endofpacket)
                        state_nxt = IDLE;
                end
            end
            DROP: begin
                if (beat && in_endofpacket)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            byte_cnt          <= 6'd0;
            reject            <= 1'b0;
            src_ip_q          <= 32'd0;
            src_port_q        <= 16'd0;
            udp_len_q         <= 16'd0;
            remaining         <= 16'd0;
            first_byte        <= 1'b0;
            out_valid         <= 1'b0;
            out_data          <= 8'd0;
            out_startofpacket <= 1'b0;
            out_endofpacket   <= 1'b0;
            out_error         <= 1'b0;
            out_src_ip        <= 32'd0;
            out_src_port      <= 16'd0;
            out_len           <= 16'd0;
            drop_count        <= '0;
        end else begin
            if (state == IDLE && beat && in_startofpacket) begin
                byte_cnt <= 6'd1;
                reject   <= 1'b0;
            end else if (state == HDR && beat) begin
                byte_cnt <= byte_cnt + 6'd1;
                reject   <= reject | hdr_bad;
                case (byte_cnt)
                    6'd26:   src_ip_q[31:24]  <= in_data;
                    6'd27:   src_ip_q[23:16]  <= in_data;
                    6'd28:   src_ip_q[15:8]   <= in_data;
                    6'd29:   src_ip_q[7:0]    <= in_data;
                    6'd34:   src_port_q[15:8] <= in_data;
                    6'd35:   src_port_q[7:0]  <= in_data;
                    6'd38:   udp_len_q[15:8]  <= in_data;
                    6'd39:   udp_len_q[7:0]   <= in_data;
                    default: ;
                endcase
            end

            if (accept) begin
                out_src_ip   <= src_ip_q;
                out_src_port <= src_port_q;
                out_len      <= udp_len_q - 16'd8;
                remaining    <= udp_len_q - 16'd8;
                first_byte   <= 1'b1;
            end

            // Output register: loads on every accepted payload byte, empties when taken.
            if (state == PAYLOAD && beat) begin
                out_valid         <= 1'b1;
                out_data          <= in_data;
                out_startofpacket <= first_byte;
                out_endofpacket   <= (remaining == 16'd1) | in_endofpacket;
                out_error         <= in_endofpacket & (remaining != 16'd1);
                first_byte        <= 1'b0;
                remaining         <= remaining - 16'd1;
            end else if (out_ready) begin
                out_valid         <= 1'b0;
                out_startofpacket <= 1'b0;
                out_endofpacket   <= 1'b0;
                out_error         <= 1'b0;
            end

            if (drop_inc && drop_count != {CNT_WIDTH{1'b1}})
                drop_count <= drop_count + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_udp_payload_extractor.sv
// Bench for udp_payload_extractor: table of frame vectors, payload scoreboard, reset corner case.
module tb_udp_payload_extractor;

    localparam logic [15:0] LOCAL_PORT = 16'd5000;
    localparam logic [31:0] MY_IP      = 32'hC0A8_010A;
    localparam logic [31:0] SRC_IP     = 32'h0A00_0001;
    localparam logic [15:0] SRC_PORT   = 16'd1234;

    logic        clk;
    logic        reset;
    logic [31:0] cfg_local_ip;
    logic        in_ready;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_startofpacket;
    logic        in_endofpacket;
    logic        out_ready = 1'b1;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_startofpacket;
    logic        out_endofpacket;
    logic        out_error;
    logic [31:0] out_src_ip;
    logic [15:0] out_src_port;
    logic [15:0] out_len;
    logic [15:0] drop_count;

    udp_payload_extractor #(.LOCAL_PORT(LOCAL_PORT), .CNT_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .cfg_local_ip(cfg_local_ip),
        .in_ready(in_ready), .in_valid(in_valid), .in_data(in_data),
        .in_startofpacket(in_startofpacket), .in_endofpacket(in_endofpacket),
        .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
        .out_startofpacket(out_startofpacket), .out_endofpacket(out_endofpacket),
        .out_error(out_error), .out_src_ip(out_src_ip), .out_src_port(out_src_port),
        .out_len(out_len), .drop_count(drop_count)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] dport;
        logic [15:0] ulen;
        int          flen;
        logic        bad_ip;
        logic        bad_csum;
        int          rmode;
        int          n_out;
        logic        trunc;
        int          drop_inc;
    } vec_t;

    vec_t        vecs[11];
    logic [7:0]  frame_buf[0:255];
    int          frame_len;
    logic [10:0] exp_q[$];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          exp_drops = 0;
    logic [15:0] exp_len = 16'd0;
    int          ready_mode = 0;
    logic        stall_prev = 1'b0;
    logic [7:0]  stall_data = 8'd0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void build_frame(input logic [15:0] dport, input logic [15:0] ulen,
                                        input int flen, input logic bad_ip, input logic bad_csum);
        logic [31:0] dst;
        logic [31:0] sum;
        logic [15:0] tot;
        dst = bad_ip ? (MY_IP ^ 32'h0000_0100) : MY_IP;
        tot = ulen + 16'd20;
        for (int i = 0; i < 256; i++) frame_buf[i] = 8'($urandom_range(0, 255));
        frame_buf[12] = 8'h08; frame_buf[13] = 8'h00;
        frame_buf[14] = 8'h45; frame_buf[15] = 8'h00;
        frame_buf[16] = tot[15:8]; frame_buf[17] = tot[7:0];
        frame_buf[22] = 8'd64; frame_buf[23] = 8'h11;
        frame_buf[24] = 8'h00; frame_buf[25] = 8'h00;
        frame_buf[26] = SRC_IP[31:24]; frame_buf[27] = SRC_IP[23:16];
        frame_buf[28] = SRC_IP[15:8];  frame_buf[29] = SRC_IP[7:0];
        frame_buf[30] = dst[31:24]; frame_buf[31] = dst[23:16];
        frame_buf[32] = dst[15:8];  frame_buf[33] = dst[7:0];
        frame_buf[34] = SRC_PORT[15:8]; frame_buf[35] = SRC_PORT[7:0];
        frame_buf[36] = dport[15:8]; frame_buf[37] = dport[7:0];
        frame_buf[38] = ulen[15:8];  frame_buf[39] = ulen[7:0];
        frame_buf[40] = 8'h00; frame_buf[41] = 8'h00;
        sum = 32'd0;
        for (int i = 14; i < 34; i += 2) sum += {16'd0, frame_buf[i], frame_buf[i+1]};
        sum = {16'd0, sum[15:0]} + {16'd0, sum[31:16]};
        sum = {16'd0, sum[15:0]} + {16'd0, sum[31:16]};
        frame_buf[24] = ~sum[15:8];
        frame_buf[25] = ~sum[7:0];
        if (bad_csum) frame_buf[24] = frame_buf[24] ^ 8'hFF;
        frame_len = flen;
    endfunction

    // Driver: sends frame bytes lo..hi, holding each beat until in_ready
    task automatic send_range(input int lo, input int hi);
        int waits;
        for (int i = lo; i <= hi; i++) begin
            @(negedge clk);
            in_valid         = 1'b1;
            in_data          = frame_buf[i];
            in_startofpacket = (i == 0);
            in_endofpacket   = (i == frame_len - 1);
            #1;
            waits = 0;
            while (!in_ready && waits < 200) begin
                @(negedge clk);
                #1;
                waits++;
            end
            if (waits >= 200) check("in_ready_timeout", 64'd0, 64'd1);
            @(posedge clk);
        end
        @(negedge clk);
        in_valid         = 1'b0;
        in_startofpacket = 1'b0;
        in_endofpacket   = 1'b0;
    endtask

    task automatic push_expected(input int n, input logic trunc);
        for (int i = 0; i < n; i++)
            exp_q.push_back({(i == 0), (i == n - 1), (trunc && i == n - 1), frame_buf[42 + i]});
    endtask

    task automatic drain_and_check(input string name);
        for (int c = 0; c < 400 && exp_q.size() != 0; c++) @(negedge clk);
        check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
        repeat (3) @(negedge clk);
        #3;
        check({name, "_drop_count"}, 64'(drop_count), 64'(exp_drops));
    endtask

    always @(negedge clk) begin
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ~out_ready;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Scoreboard monitor: samples mid-cycle the values that the next rising edge will see
    always @(negedge clk) begin
        logic [10:0] e;
        #2;
        if (stall_prev)
            check("stall_hold", {out_valid, out_data}, {1'b1, stall_data});
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_out: got data 0x%0h, expected no output", out_data);
            end else begin
                e = exp_q.pop_front();
                check("payload_beat", {out_startofpacket, out_endofpacket, out_error, out_data}, e);
                if (out_startofpacket) begin
                    check("out_len", out_len, exp_len);
                    check("out_src_ip", out_src_ip, SRC_IP);
                    check("out_src_port", out_src_port, SRC_PORT);
                end
            end
        end
        stall_prev = out_valid && !out_ready;
        stall_data = out_data;
    end

    initial begin
        cfg_local_ip     = MY_IP;
        reset            = 1'b1;
        in_valid         = 1'b0;
        in_data          = 8'd0;
        in_startofpacket = 1'b0;
        in_endofpacket   = 1'b0;

        //        dport           ulen    flen ip csum rmode n_out trunc drop
        vecs[0]  = '{LOCAL_PORT,        16'd18,  60, 0, 0, 0, 10,  0, 0};
        vecs[1]  = '{LOCAL_PORT + 16'd1, 16'd18, 60, 0, 0, 0, 0,   0, 1};
        vecs[2]  = '{LOCAL_PORT,        16'd18,  60, 0, 0, 1, 10,  0, 0};
        vecs[3]  = '{LOCAL_PORT,        16'd100, 48, 0, 0, 0, 6,   1, 0};
        vecs[4]  = '{LOCAL_PORT,        16'd8,   60, 0, 0, 0, 0,   0, 1};
        vecs[5]  = '{LOCAL_PORT,        16'd9,   60, 0, 0, 1, 1,   0, 0};
        vecs[6]  = '{LOCAL_PORT,        16'd60,  94, 0, 0, 2, 52,  0, 0};
        vecs[7]  = '{LOCAL_PORT,        16'd18,  60, 1, 0, 0, 0,   0, 1};
`ifdef UDP_RX_IP_CSUM_CHECK_EN
        vecs[8]  = '{LOCAL_PORT,        16'd18,  60, 0, 1, 0, 0,   0, 1};
`else
        vecs[8]  = '{LOCAL_PORT,        16'd18,  60, 0, 1, 0, 10,  0, 0};
`endif
        vecs[9]  = '{LOCAL_PORT,        16'd18,  30, 0, 0, 0, 0,   0, 1};
        vecs[10] = '{LOCAL_PORT,        16'd200, 242, 0, 0, 2, 192, 0, 0};

        repeat (3) @(negedge clk);
        #1;
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_outputs", {out_data, out_startofpacket, out_endofpacket, out_error,
                              out_len, out_src_port}, 64'd0);
        check("rst_drop_count", drop_count, 16'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("idle_in_ready", in_ready, 1'b1);

        // Stray beats without sop while idle must be ignored
        for (int k = 0; k < 3; k++) begin
            in_valid       = 1'b1;
            in_data        = 8'hA0 + 8'(k);
            in_endofpacket = (k == 1);
            @(posedge clk);
            @(negedge clk);
        end
        in_valid       = 1'b0;
        in_endofpacket = 1'b0;
        drain_and_check("stray");

        for (int v = 0; v < 11; v++) begin
            ready_mode = vecs[v].rmode;
            build_frame(vecs[v].dport, vecs[v].ulen, vecs[v].flen, vecs[v].bad_ip, vecs[v].bad_csum);
            exp_len = vecs[v].ulen - 16'd8;
            push_expected(vecs[v].n_out, vecs[v].trunc);
            exp_drops += vecs[v].drop_inc;
            send_range(0, frame_len - 1);
            drain_and_check($sformatf("vec%0d", v));
            ready_mode = 0;
        end

        // Reset pulse arriving at payload byte 3, then a clean frame
        ready_mode = 0;
        repeat (2) @(negedge clk);
        build_frame(LOCAL_PORT, 16'd18, 60, 1'b0, 1'b0);
        exp_len = 16'd10;
        for (int i = 0; i < 3; i++)
            exp_q.push_back({(i == 0), 1'b0, 1'b0, frame_buf[42 + i]});
        send_range(0, 44);
        in_valid = 1'b1;
        in_data  = frame_buf[45];
        reset    = 1'b1;
        #1;
        check("mid_rst_in_ready", in_ready, 1'b0);
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b0;
        exp_drops = 0;
        #1;
        check("post_rst_out_valid", out_valid, 1'b0);
        check("post_rst_eop", out_endofpacket, 1'b0);
        check("post_rst_queue", 64'(exp_q.size()), 64'd0);
        build_frame(LOCAL_PORT, 16'd18, 60, 1'b0, 1'b0);
        push_expected(10, 1'b0);
        send_range(0, frame_len - 1);
        drain_and_check("after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
